// File: rtl/kernel_fdtd_2d_addr_gen_if.sv
// Address stream from the fdtd-2d address generator to the array-access stage.
interface kernel_fdtd_2d_addr_gen_if;
  logic        addr_valid;
  logic        addr_ready;
  logic [19:0] addr;
  logic        addr_last;

  modport master (output addr_valid, addr, addr_last, input addr_ready);
  modport slave  (input addr_valid, addr, addr_last, output addr_ready);
endinterface

// File: rtl/kernel_fdtd_2d_addr_gen.sv
// kernel_fdtd_2d_addr_gen: row-major i*NY+j address generator around an
// external MUL_LAT-stage multiplier. j rides a tag pipeline matched to the
// multiplier latency and is added to the returned product.
// Optional build macro FDTD_ADDR_HALO_EN: sweep interior points only
// (i from 1, j wrapping to 1).
module kernel_fdtd_2d_addr_gen #(
  parameter int NX      = 500,
  parameter int NY      = 1000,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        mul_ce,
  output logic [9:0]  mul_din0,
  output logic [10:0] mul_din1,
  input  logic [19:0] mul_dout,
  kernel_fdtd_2d_addr_gen_if.master aout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

`ifdef FDTD_ADDR_HALO_EN
  localparam logic [9:0]  I_START = 10'd1;
  localparam logic [10:0] J_START = 11'd1;
`else
  localparam logic [9:0]  I_START = 10'd0;
  localparam logic [10:0] J_START = 11'd0;
`endif
  localparam logic [9:0]  I_LAST = 10'(NX - 1);
  localparam logic [10:0] J_LAST = 11'(NY - 1);

  logic [1:0]                state;
  logic [9:0]                i;
  logic [10:0]               j;
  logic [MUL_LAT-1:0]        vld_pipe;
  logic [MUL_LAT-1:0]        last_pipe;
  logic [MUL_LAT-1:0][10:0]  j_pipe;
  logic                      adv;
  logic                      issue;
  logic                      last_pair;

  // Everything downstream of the counters moves together; a held output beat
  // freezes the multiplier and tags so no result is lost or duplicated.
  assign adv       = !(aout.addr_valid && !aout.addr_ready);
  assign issue     = (state == S_RUN) && adv;
  assign last_pair = (i == I_LAST) && (j == J_LAST);

  assign mul_ce   = adv;
  assign mul_din0 = (state == S_RUN) ? i : 10'd0;
  assign mul_din1 = 11'(NY);
  assign busy     = (state != S_IDLE);
  // Sweep ends when the final beat leaves and nothing is still in flight.
  assign done     = (state == S_DRAIN) && !(|vld_pipe) &&
                    aout.addr_valid && aout.addr_last && aout.addr_ready;

  // Sweep FSM and (i, j) index counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      i     <= I_START;
      j     <= J_START;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          i     <= I_START;
          j     <= J_START;
        end
        S_RUN: if (adv) begin
          if (j == J_LAST) begin
            j <= J_START;
            if (i == I_LAST) state <= S_DRAIN;
            else             i     <= i + 10'd1;
          end else begin
            j <= j + 11'd1;
          end
        end
        S_DRAIN: if (done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline aligned with the multiplier, then the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe        <= '0;
      last_pipe       <= '0;
      j_pipe          <= '0;
      aout.addr_valid <= 1'b0;
      aout.addr       <= 20'd0;
      aout.addr_last  <= 1'b0;
    end else if (adv) begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && last_pair;
      j_pipe[0]    <= j;
      for (int k = 1; k < MUL_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
        j_pipe[k]    <= j_pipe[k-1];
      end
      aout.addr_valid <= vld_pipe[MUL_LAT-1];
      aout.addr       <= mul_dout + {9'd0, j_pipe[MUL_LAT-1]};
      aout.addr_last  <= vld_pipe[MUL_LAT-1] && last_pipe[MUL_LAT-1];
    end
  end

endmodule

// File: tb/tb_kernel_fdtd_2d_addr_gen.sv
// Bench for kernel_fdtd_2d_addr_gen: per-cycle vector table on a 3x4 grid,
// plus a random-ready scoreboard run on a 50x100 grid.
module tb_kernel_fdtd_2d_addr_gen;
  localparam int NX = 3, NY = 4, LAT = 3;
  localparam int NX2 = 50, NY2 = 100;
`ifdef FDTD_ADDR_HALO_EN
  localparam int ORG = 1;
`else
  localparam int ORG = 0;
`endif
  localparam int N  = (NX - ORG) * (NY - ORG);
  localparam int N2 = (NX2 - ORG) * (NY2 - ORG);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, start2 = 1'b0;
  logic busy, done, mul_ce, busy2, done2, mul_ce2;
  logic [9:0]  din0, din0_2;
  logic [10:0] din1, din1_2;
  logic [19:0] dout, dout2;

  kernel_fdtd_2d_addr_gen_if a_if();
  kernel_fdtd_2d_addr_gen_if b_if();

  kernel_fdtd_2d_addr_gen #(.NX(NX), .NY(NY), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mul_ce(mul_ce), .mul_din0(din0), .mul_din1(din1), .mul_dout(dout),
    .aout(a_if.master));

  kernel_fdtd_2d_addr_gen #(.NX(NX2), .NY(NY2), .MUL_LAT(LAT)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .mul_ce(mul_ce2), .mul_din0(din0_2), .mul_din1(din1_2), .mul_dout(dout2),
    .aout(b_if.master));

  // Multiplier models: LAT ce-enabled register stages.
  logic [19:0] mp [LAT];
  logic [19:0] mp2 [LAT];
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      mp[0] <= {10'd0, din0} * {9'd0, din1};
      for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    if (mul_ce2) begin
      mp2[0] <= {10'd0, din0_2} * {9'd0, din1_2};
      for (int k = 1; k < LAT; k++) mp2[k] <= mp2[k-1];
    end
  end
  assign dout  = mp[LAT-1];
  assign dout2 = mp2[LAT-1];

  typedef struct {
    int tst; int cyc;
    bit rst; bit st; bit rdy;
    bit chk; bit zero;
    bit ev; bit el; bit ed; bit eb; int ea;
  } vec_t;

  vec_t vecs[$];
  int   E[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int tst, int c, bit rst, bit st, bit rdy, bit zero,
                              int idx, bit eb, bit acc);
    vec_t r;
    r.tst = tst; r.cyc = c; r.rst = rst; r.st = st; r.rdy = rdy;
    r.chk = !rst; r.zero = zero; r.eb = eb;
    r.ev  = (idx >= 0) && (idx < N);
    r.ea  = r.ev ? E[idx] : 0;
    r.el  = r.ev && (idx == N - 1);
    r.ed  = r.el && acc && rdy;
    return r;
  endfunction

  initial begin
    string nm;
    int idx, ei, ej, beats, cyc;
    bit fin, prev_hold;
    logic [19:0] prev_addr;

    a_if.addr_ready = 1'b1;
    b_if.addr_ready = 1'b0;

    for (int i = ORG; i < NX; i++)
      for (int j = ORG; j < NY; j++) E.push_back(i * NY + j);

    // 1: ready high, start at cycle 0
    vecs.push_back(mk(1, -1, 1, 0, 1, 0, -1, 0, 0));
    for (int c = 0; c <= N + 5; c++)
      vecs.push_back(mk(1, c, 0, c == 0, 1, c == 0, c - 5, c >= 1 && c <= N + 4, 1));
    // 2: ready low for cycles 7..9
    vecs.push_back(mk(2, -1, 1, 0, 1, 0, -1, 0, 0));
    for (int c = 0; c <= N + 8; c++) begin
      idx = (c < 7) ? c - 5 : (c <= 9) ? 2 : c - 8;
      vecs.push_back(mk(2, c, 0, c == 0, !(c >= 7 && c <= 9), c == 0, idx,
                        c >= 1 && c <= N + 7, 1));
    end
    // 3: extra starts mid-sweep and in the done cycle ignored; one later accepted
    vecs.push_back(mk(3, -1, 1, 0, 1, 0, -1, 0, 0));
    for (int c = 0; c <= N + 6; c++)
      vecs.push_back(mk(3, c, 0, c == 0 || c == 8 || c == N + 4 || c == N + 5, 1, c == 0,
                        (c <= N + 5) ? c - 5 : -1,
                        (c >= 1 && c <= N + 4) || c == N + 6, 1));
    // 4: reset at cycle 8, restart at cycle 10
    vecs.push_back(mk(4, -1, 1, 0, 1, 0, -1, 0, 0));
    for (int c = 0; c <= N + 15; c++) begin
      if (c <= 8)
        vecs.push_back(mk(4, c, c == 8, c == 0, 1, c == 0, c - 5, c >= 1, 1));
      else if (c <= 10)
        vecs.push_back(mk(4, c, 0, c == 10, 1, c == 9, -1, 0, 1));
      else
        vecs.push_back(mk(4, c, 0, 0, 1, 0, c - 15, c <= N + 14, 1));
    end
    // reset record at cycle 8 of test 4 must still be checked (outputs pre-reset)
    foreach (vecs[k]) if (vecs[k].tst == 4 && vecs[k].cyc == 8) vecs[k].chk = 1;

    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst; start = vecs[k].st; a_if.addr_ready = vecs[k].rdy;
      #1;
      if (vecs[k].chk) begin
        nm = $sformatf("t%0d c%0d", vecs[k].tst, vecs[k].cyc);
        chk({nm, " valid"}, a_if.addr_valid, vecs[k].ev);
        chk({nm, " busy"}, busy, vecs[k].eb);
        chk({nm, " done"}, done, vecs[k].ed);
        chk({nm, " din1"}, din1, NY);
        if (vecs[k].ev) begin
          chk({nm, " addr"}, a_if.addr, vecs[k].ea);
          chk({nm, " last"}, a_if.addr_last, vecs[k].el);
        end
        if (vecs[k].zero) begin
          chk({nm, " rst addr"}, a_if.addr, 0);
          chk({nm, " rst last"}, a_if.addr_last, 0);
          chk({nm, " rst din0"}, din0, 0);
          chk({nm, " rst ce"}, mul_ce, 1);
        end
      end
    end

    // Random-ready scoreboard on the larger grid
    @(negedge clk); reset = 1'b0; start = 1'b0;
    ei = ORG; ej = ORG; beats = 0; fin = 0; prev_hold = 0; prev_addr = '0;
    for (cyc = 0; cyc < 40000 && !fin; cyc++) begin
      @(negedge clk);
      start2 = (cyc == 0);
      b_if.addr_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (din1_2 !== 11'(NY2)) chk("r din1", din1_2, NY2);
      if (prev_hold) chk("r hold", b_if.addr, prev_addr);
      if (b_if.addr_valid && b_if.addr_ready) begin
        chk("r addr", b_if.addr, ei * NY2 + ej);
        chk("r last", b_if.addr_last, beats == N2 - 1);
        chk("r done", done2, beats == N2 - 1);
        beats++;
        if (beats == N2) fin = 1;
        if (ej == NY2 - 1) begin ej = ORG; ei++; end
        else ej++;
      end else if (done2) begin
        chk("r stray done", done2, 0);
      end
      prev_hold = b_if.addr_valid && !b_if.addr_ready;
      prev_addr = b_if.addr;
    end
    chk("r timeout", fin, 1);
    chk("r beats", beats, N2);
    @(negedge clk); #1;
    chk("r busy end", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
